uart_hex_rx: RTL and testbench

- Receives 8N1 UART characters on `rxd` and parses ASCII hexadecimal text into a 32-bit word.
- It decodes the "hex digits + CR LF" line format that the board's UART transmit path produces, so a host terminal can write values into the register map.
- It sits beside the TX path in the top level; `word` and `word_vld` feed a register write port.

---
 rtl/uart_hex_rx.sv | 176 +++++++++++++++++
 tb/tb_uart_hex_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_rx.sv
// 8N1 UART receiver that parses "hex digits + CR" lines into a 32-bit word.
// Define UART_HEX_RX_LOWER_EN to accept lowercase 'a'-'f' as hex digits.
module uart_hex_rx #(
  parameter int CLK_DIV    = 10416,
  parameter int MAX_DIGITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic [31:0] word,
  output logic        word_vld,
  output logic [3:0]  ndigits,
  output logic        err,
  output logic        busy
);

  localparam int              CNT_W     = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       MAX_CNT   = 4'(MAX_DIGITS);
  localparam logic [7:0]       CHAR_CR   = 8'h0D;
  localparam logic [7:0]       CHAR_LF   = 8'h0A;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Returns {is_digit, nibble} for one received character.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    hex_decode = 5'b0_0000;
    if (c >= 8'h30 && c <= 8'h39) begin
      hex_decode = {1'b1, c[3:0]};
    end else if (c >= 8'h41 && c <= 8'h46) begin
      hex_decode = {1'b1, c[3:0] + 4'd9};
`ifdef UART_HEX_RX_LOWER_EN
    end else if (c >= 8'h61 && c <= 8'h66) begin
      hex_decode = {1'b1, c[3:0] + 4'd9};
`endif
    end else begin
      hex_decode = 5'b0_0000;
    end
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             rxd_s1_q, rxd_s2_q;
  logic [1:0]       settle_q;
  logic             armed_q;
  logic [31:0]      acc_q;
  logic [3:0]       dcnt_q;
  logic             discard_q;
  logic [31:0]      word_q;
  logic [3:0]       ndigits_q;
  logic             word_vld_q, err_q;

  logic [4:0]       hex_d;
  logic             edge_d;

  // The synchroniser resets high, so a fall is only trusted once the line has
  // genuinely been observed high after reset or after the previous start edge.
  assign hex_d  = hex_decode(shift_q);
  assign edge_d = armed_q & ~rxd_s2_q;

  // Receiver FSM, character parser and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= CNT_ZERO;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      settle_q   <= 2'd0;
      armed_q    <= 1'b0;
      acc_q      <= 32'h0000_0000;
      dcnt_q     <= 4'd0;
      discard_q  <= 1'b0;
      word_q     <= 32'h0000_0000;
      ndigits_q  <= 4'd0;
      word_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rxd_s1_q   <= rxd;
      rxd_s2_q   <= rxd_s1_q;
      word_vld_q <= 1'b0;
      err_q      <= 1'b0;
      if (settle_q != 2'd2) begin
        settle_q <= settle_q + 2'd1;
      end
      case (state_q)
        IDLE: begin
          if (edge_d) begin
            state_q <= START;
            cnt_q   <= HALF_LOAD;
            armed_q <= 1'b0;
          end else if (settle_q == 2'd2 && rxd_s2_q) begin
            armed_q <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == CNT_ZERO) begin
            state_q <= rxd_s2_q ? IDLE : DATA;
            cnt_q   <= FULL_LOAD;
            bit_q   <= 3'd0;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_q == CNT_ZERO) begin
            shift_q <= {rxd_s2_q, shift_q[7:1]};
            cnt_q   <= FULL_LOAD;
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        STOP: begin
          if (cnt_q == CNT_ZERO) begin
            state_q <= IDLE;
            if (!rxd_s2_q) begin
              err_q     <= 1'b1;
              acc_q     <= 32'h0000_0000;
              dcnt_q    <= 4'd0;
              discard_q <= 1'b0;
            end else if (discard_q) begin
              if (shift_q == CHAR_CR) begin
                acc_q     <= 32'h0000_0000;
                dcnt_q    <= 4'd0;
                discard_q <= 1'b0;
              end
            end else if (hex_d[4]) begin
              if (dcnt_q == MAX_CNT) begin
                err_q     <= 1'b1;
                discard_q <= 1'b1;
              end else begin
                acc_q  <= {acc_q[27:0], hex_d[3:0]};
                dcnt_q <= dcnt_q + 4'd1;
              end
            end else if (shift_q == CHAR_CR) begin
              if (dcnt_q != 4'd0) begin
                word_q     <= acc_q;
                ndigits_q  <= dcnt_q;
                word_vld_q <= 1'b1;
              end
              acc_q     <= 32'h0000_0000;
              dcnt_q    <= 4'd0;
              discard_q <= 1'b0;
            end else if (shift_q != CHAR_LF) begin
              err_q  <= 1'b1;
              acc_q  <= 32'h0000_0000;
              dcnt_q <= 4'd0;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign word     = word_q;
  assign word_vld = word_vld_q;
  assign ndigits  = ndigits_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_hex_rx.sv
// Scoreboard bench for uart_hex_rx: stimulus pushes expected events, a monitor
// process pops and compares on every word_vld/err pulse and on quiet-time probes.
module tb_uart_hex_rx;

  localparam int CLK_DIV    = 16;
  localparam int MAX_DIGITS = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxd;
  logic [31:0] word;
  logic        word_vld;
  logic [3:0]  ndigits;
  logic        err;
  logic        busy;

  uart_hex_rx #(.CLK_DIV(CLK_DIV), .MAX_DIGITS(MAX_DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .word     (word),
    .word_vld (word_vld),
    .ndigits  (ndigits),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_err;
    logic [31:0] w;
    logic [3:0]  n;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        probe_req = 1'b0;
  string       probe_name;
  logic [31:0] p_word;
  logic [3:0]  p_nd;
  logic        p_busy;
  logic        p_run;
  int          busy_run = 0;
  int          last_run = 0;

  task automatic exp_vld(input logic [31:0] w, input logic [3:0] n);
    exp_t e;
    e.is_err = 1'b0; e.w = w; e.n = n;
    exp_q.push_back(e);
  endtask

  task automatic exp_err();
    exp_t e;
    e.is_err = 1'b1; e.w = 32'h0; e.n = 4'd0;
    exp_q.push_back(e);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    wait_clk(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_clk(CLK_DIV);
    end
    rxd = stop;
    wait_clk(CLK_DIV);
    rxd = 1'b1;
    wait_clk(4);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], 1'b1);
    end
  endtask

  task automatic probe(input string nm, input logic [31:0] w, input logic [3:0] n,
                       input logic b, input logic r);
    probe_name = nm; p_word = w; p_nd = n; p_busy = b; p_run = r;
    probe_req = 1'b1;
    @(negedge clk);
    #1;
    probe_req = 1'b0;
  endtask

  // Monitor: sole owner of the check counters.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy) begin
        busy_run++;
      end else begin
        if (busy_run != 0) last_run = busy_run;
        busy_run = 0;
      end
      if (probe_req) begin
        checks++;
        if (word !== p_word || ndigits !== p_nd || busy !== p_busy || word_vld !== 1'b0 ||
            err !== 1'b0 || exp_q.size() != 0 ||
            (p_run && (last_run == 0 || last_run > CLK_DIV / 2 + 1))) begin
          errors++;
          $display("FAIL %s: got word=%h nd=%0d busy=%b vld=%b err=%b pending=%0d busy_run=%0d; required word=%h nd=%0d busy=%b vld=0 err=0 pending=0",
                   probe_name, word, ndigits, busy, word_vld, err, exp_q.size(), last_run,
                   p_word, p_nd, p_busy);
        end
      end
      if (!rst && (word_vld || err)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got vld=%b err=%b word=%h nd=%0d; required no event",
                   word_vld, err, word, ndigits);
        end else begin
          e = exp_q.pop_front();
          if ((word_vld && err) || err !== e.is_err || word_vld !== !e.is_err ||
              (!e.is_err && (word !== e.w || ndigits !== e.n))) begin
            errors++;
            $display("FAIL event: got vld=%b err=%b word=%h nd=%0d; required %s word=%h nd=%0d",
                     word_vld, err, word, ndigits, e.is_err ? "err" : "vld", e.w, e.n);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    wait_clk(5);
    probe("reset", 32'h0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    wait_clk(10);

    exp_vld(32'h1A2B_3C4D, 4'd8);
    send_str("1A2B3C4D\015\012");

    exp_vld(32'h0000_00FF, 4'd2);
    send_str("FF\015");
    send_str("\015");
    wait_clk(20);
    probe("lone_cr", 32'h0000_00FF, 4'd2, 1'b0, 1'b0);

    exp_err();
    exp_vld(32'h0000_0007, 4'd1);
    send_str("123456789\015");
    send_str("7\015");

    send_str("3");
    exp_err();
    send_byte(8'h41, 1'b0);
    wait_clk(16);
    exp_vld(32'h0000_0005, 4'd1);
    send_str("5\015");
    wait_clk(20);

    rxd = 1'b0;
    wait_clk(4);
    rxd = 1'b1;
    wait_clk(40);
    probe("glitch", 32'h0000_0005, 4'd1, 1'b0, 1'b1);

`ifdef UART_HEX_RX_LOWER_EN
    exp_vld(32'h0000_00AB, 4'd2);
`else
    exp_err();
    exp_err();
`endif
    send_str("ab\015");
    wait_clk(20);

    // '7' = 0x37: start, bits 1,1,1 then reset while bit3 (0) holds the line low.
    rxd = 1'b0;
    wait_clk(CLK_DIV);
    rxd = 1'b1;
    wait_clk(3 * CLK_DIV);
    rxd = 1'b0;
    wait_clk(4);
    rst = 1'b1;
    wait_clk(2);
    probe("rst_mid", 32'h0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    wait_clk(40);
    probe("no_rearm", 32'h0, 4'd0, 1'b0, 1'b0);
    rxd = 1'b1;
    wait_clk(20);

    exp_vld(32'h0000_0009, 4'd1);
    send_str("9\015");
    wait_clk(20);
    probe("final", 32'h0000_0009, 4'd1, 1'b0, 1'b0);

    wait_clk(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
